// File: rtl/caesar_msg_ctrl.sv
// caesar_msg_ctrl
// Message-level controller for the 3-stage Caesar cipher core.
//  - Holds key/mode configuration and validates it on start (k1,k3 <= 26, k1 != k3).
//  - Streams characters into the core one per cycle under ready/valid flow control.
//  - Collects core results into a 2-entry output FIFO and flags the last character.
//  - Counts characters the core rejected (saturating).
//
// Optional build macro: PASSTHRU_NONLETTER_EN
//   When defined, characters rejected by the core as non-letters are passed through
//   unchanged (from a 1-deep shadow of the issued char) and are not counted as errors.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cfg_we, cfg_mode, cfg_d1,  configuration write (accepted in IDLE only)
//   cfg_k1, cfg_d3, cfg_k3
//   start, msg_len             message start pulse and length (sampled in IDLE)
//   busy, done, key_err,       message status
//   err_count
//   in_valid, in_char, in_ready            host input stream
//   out_valid, out_char, out_err,          output stream (head of output FIFO)
//   out_last, out_ready
//   core_op, core_valid, core_d1, core_k1, interface to the cipher core
//   core_d3, core_k3, core_ptxt, core_ctxt,
//   core_ready, core_err_char
module caesar_msg_ctrl #(
    parameter int LEN_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic             cfg_mode,
    input  logic             cfg_d1,
    input  logic [4:0]       cfg_k1,
    input  logic             cfg_d3,
    input  logic [4:0]       cfg_k3,
    input  logic             start,
    input  logic [LEN_W-1:0] msg_len,
    output logic             busy,
    output logic             done,
    output logic             key_err,
    output logic [CNT_W-1:0] err_count,
    input  logic             in_valid,
    input  logic [7:0]       in_char,
    output logic             in_ready,
    output logic             out_valid,
    output logic [7:0]       out_char,
    output logic             out_err,
    output logic             out_last,
    input  logic             out_ready,
    output logic             core_op,
    output logic             core_valid,
    output logic             core_d1,
    output logic [4:0]       core_k1,
    output logic             core_d3,
    output logic [4:0]       core_k3,
    output logic [7:0]       core_ptxt,
    input  logic [7:0]       core_ctxt,
    input  logic             core_ready,
    input  logic             core_err_char
);

    localparam logic [4:0] KEY_MAX = 5'd26;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic             busy_q, busy_d;
    logic             key_err_q, key_err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] issued_q, issued_d;
    logic [LEN_W-1:0] returned_q, returned_d;
    logic             inflight_q, inflight_d;
    logic [7:0]       ptxt_q, ptxt_d;
    logic             mode_q, mode_d;
    logic             d1_q, d1_d;
    logic [4:0]       k1_q, k1_d;
    logic             d3_q, d3_d;
    logic [4:0]       k3_q, k3_d;

    // 2-entry output FIFO
    logic [7:0]       buf_char_q [2];
    logic [7:0]       buf_char_d [2];
    logic [1:0]       buf_err_q, buf_err_d;
    logic [1:0]       buf_last_q, buf_last_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       occ_q, occ_d;

`ifdef PASSTHRU_NONLETTER_EN
    logic [7:0]       shadow_q, shadow_d;
`else
    logic             unused_err_char;
    assign unused_err_char = core_err_char;
`endif

    logic       pop;
    logic       issue;
    logic [2:0] slots_used;
    logic       key_bad;
    logic [7:0] push_char;
    logic       push_err;
    logic       push_last;

    always_comb begin
        state_d       = state_q;
        busy_d        = busy_q;
        key_err_d     = key_err_q;
        err_cnt_d     = err_cnt_q;
        len_d         = len_q;
        issued_d      = issued_q;
        returned_d    = returned_q;
        inflight_d    = 1'b0;
        ptxt_d        = ptxt_q;
        mode_d        = mode_q;
        d1_d          = d1_q;
        k1_d          = k1_q;
        d3_d          = d3_q;
        k3_d          = k3_q;
        buf_char_d    = buf_char_q;
        buf_err_d     = buf_err_q;
        buf_last_d    = buf_last_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
`ifdef PASSTHRU_NONLETTER_EN
        shadow_d      = shadow_q;
`endif
        push_char     = 8'h00;
        push_err      = 1'b0;
        push_last     = 1'b0;

        pop = (occ_q != 2'd0) && out_ready;

        // A slot freed by this cycle's pop can be reused immediately, which is
        // what sustains one character per cycle with out_ready held high.
        slots_used = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
        issue = (state_q == S_RUN) && (issued_q < len_q) && in_valid &&
                (slots_used < 3'd2);

        key_bad = (k1_q > KEY_MAX) || (k3_q > KEY_MAX) || (k1_q == k3_q);

        if (issue) begin
            inflight_d = 1'b1;
            ptxt_d     = in_char;
            issued_d   = issued_q + LEN_W'(1);
`ifdef PASSTHRU_NONLETTER_EN
            shadow_d   = in_char;
`endif
        end

        // Capture is keyed off our own inflight flag: the core withholds
        // ready when it rejects a character, so ready cannot mark the slot.
        if (inflight_q) begin
            push_last  = ((returned_q + LEN_W'(1)) == len_q);
            returned_d = returned_q + LEN_W'(1);
            if (core_ready) begin
                push_char = core_ctxt;
`ifdef PASSTHRU_NONLETTER_EN
            end else if (core_err_char) begin
                push_char = shadow_q;
`endif
            end else begin
                push_err = 1'b1;
                if (err_cnt_q != {CNT_W{1'b1}}) begin
                    err_cnt_d = err_cnt_q + CNT_W'(1);
                end
            end
            buf_char_d[wr_ptr_q] = push_char;
            buf_err_d[wr_ptr_q]  = push_err;
            buf_last_d[wr_ptr_q] = push_last;
            wr_ptr_d             = ~wr_ptr_q;
        end

        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        occ_d = occ_q + 2'(inflight_q) - 2'(pop);

        case (state_q)
            S_IDLE: begin
                if (cfg_we) begin
                    mode_d    = cfg_mode;
                    d1_d      = cfg_d1;
                    k1_d      = cfg_k1;
                    d3_d      = cfg_d3;
                    k3_d      = cfg_k3;
                    key_err_d = 1'b0;
                end
                if (start) begin
                    len_d   = msg_len;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (key_bad) begin
                    key_err_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    key_err_d  = 1'b0;
                    err_cnt_d  = '0;
                    busy_d     = 1'b1;
                    issued_d   = '0;
                    returned_d = '0;
                    state_d    = (len_q == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (issued_q == len_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Finish as the last entry leaves so done follows out_last by one cycle.
                if ((returned_q == len_q) &&
                    ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop))) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q        <= 1'b0;
            key_err_q     <= 1'b0;
            err_cnt_q     <= '0;
            len_q         <= '0;
            issued_q      <= '0;
            returned_q    <= '0;
            inflight_q    <= 1'b0;
            ptxt_q        <= 8'h00;
            mode_q        <= 1'b0;
            d1_q          <= 1'b0;
            k1_q          <= 5'd0;
            d3_q          <= 1'b0;
            k3_q          <= 5'd0;
            buf_char_q[0] <= 8'h00;
            buf_char_q[1] <= 8'h00;
            buf_err_q     <= 2'b00;
            buf_last_q    <= 2'b00;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            occ_q         <= 2'd0;
`ifdef PASSTHRU_NONLETTER_EN
            shadow_q      <= 8'h00;
`endif
        end else begin
            busy_q        <= busy_d;
            key_err_q     <= key_err_d;
            err_cnt_q     <= err_cnt_d;
            len_q         <= len_d;
            issued_q      <= issued_d;
            returned_q    <= returned_d;
            inflight_q    <= inflight_d;
            ptxt_q        <= ptxt_d;
            mode_q        <= mode_d;
            d1_q          <= d1_d;
            k1_q          <= k1_d;
            d3_q          <= d3_d;
            k3_q          <= k3_d;
            buf_char_q    <= buf_char_d;
            buf_err_q     <= buf_err_d;
            buf_last_q    <= buf_last_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            occ_q         <= occ_d;
`ifdef PASSTHRU_NONLETTER_EN
            shadow_q      <= shadow_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = (state_q == S_DONE);
    assign key_err    = key_err_q;
    assign err_count  = err_cnt_q;
    assign in_ready   = issue;
    assign out_valid  = (occ_q != 2'd0);
    assign out_char   = buf_char_q[rd_ptr_q];
    assign out_err    = buf_err_q[rd_ptr_q];
    assign out_last   = buf_last_q[rd_ptr_q];
    assign core_op    = mode_q;
    assign core_valid = inflight_q;
    assign core_d1    = d1_q;
    assign core_k1    = k1_q;
    assign core_d3    = d3_q;
    assign core_k3    = k3_q;
    assign core_ptxt  = ptxt_q;

endmodule

// File: tb/tb_caesar_msg_ctrl.sv
module tb_caesar_msg_ctrl;
    localparam int LEN_W = 8;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cfg_we, cfg_mode, cfg_d1, cfg_d3;
    logic [4:0]       cfg_k1, cfg_k3;
    logic             start;
    logic [LEN_W-1:0] msg_len;
    logic             busy, done, key_err;
    logic [CNT_W-1:0] err_count;
    logic             in_valid, in_ready;
    logic [7:0]       in_char;
    logic             out_valid, out_err, out_last, out_ready;
    logic [7:0]       out_char;
    logic             core_op, core_valid, core_d1, core_d3;
    logic [4:0]       core_k1, core_k3;
    logic [7:0]       core_ptxt, core_ctxt;
    logic             core_ready, core_err_char;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    caesar_msg_ctrl #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_mode(cfg_mode), .cfg_d1(cfg_d1), .cfg_k1(cfg_k1),
        .cfg_d3(cfg_d3), .cfg_k3(cfg_k3),
        .start(start), .msg_len(msg_len),
        .busy(busy), .done(done), .key_err(key_err), .err_count(err_count),
        .in_valid(in_valid), .in_char(in_char), .in_ready(in_ready),
        .out_valid(out_valid), .out_char(out_char), .out_err(out_err),
        .out_last(out_last), .out_ready(out_ready),
        .core_op(core_op), .core_valid(core_valid),
        .core_d1(core_d1), .core_k1(core_k1), .core_d3(core_d3), .core_k3(core_k3),
        .core_ptxt(core_ptxt), .core_ctxt(core_ctxt),
        .core_ready(core_ready), .core_err_char(core_err_char)
    );

    // Behavioural core: net shift = +/-k1, +8, +/-k3 (negated for decrypt), case kept.
    function automatic logic [7:0] cipher(input logic [7:0] c, input logic op,
                                          input logic d1, input logic [4:0] k1,
                                          input logic d3, input logic [4:0] k3);
        int s, base, idx;
        s = (d1 ? -int'(k1) : int'(k1)) + 8 + (d3 ? -int'(k3) : int'(k3));
        if (op) s = -s;
        base = (c >= 8'h61) ? 32'h61 : 32'h41;
        idx = ((int'(c) - base + s) % 26 + 26) % 26;
        return 8'(base + idx);
    endfunction

    always_comb begin
        logic letter;
        letter = ((core_ptxt >= 8'h41) && (core_ptxt <= 8'h5A)) ||
                 ((core_ptxt >= 8'h61) && (core_ptxt <= 8'h7A));
        core_ready    = core_valid && letter;
        core_err_char = core_valid && !letter;
        core_ctxt     = 8'hEE;
        if (letter) core_ctxt = cipher(core_ptxt, core_op, core_d1, core_k1, core_d3, core_k3);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_cfg(input logic m, input logic d1, input logic [4:0] k1,
                          input logic d3, input logic [4:0] k3);
        @(negedge clk);
        cfg_we = 1'b1; cfg_mode = m; cfg_d1 = d1; cfg_k1 = k1; cfg_d3 = d3; cfg_k3 = k3;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    typedef struct {
        logic        mode, d1;
        logic [4:0]  k1;
        logic        d3;
        logic [4:0]  k3;
        int          len;
        logic [31:0] ch;    // char i at [31-8i -: 8]
        logic [31:0] eo;    // expected output chars, same layout
        logic [3:0]  ee;    // expected out_err, bit i for char i
        int          ecnt;
        logic        kbad;
        int          hold;  // loop cycles with out_ready=0 from start
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input int n, input vec_t v);
        int idx, nout, last_cyc, done_cyc, hs_hold;
        logic done_seen;
        idx = 0; nout = 0; last_cyc = -1; done_cyc = -1; hs_hold = 0; done_seen = 1'b0;
        do_cfg(v.mode, v.d1, v.k1, v.d3, v.k3);
        start = 1'b1; msg_len = LEN_W'(v.len);
        @(negedge clk);
        start = 1'b0;
        if (v.kbad) begin
            in_valid = 1'b1; in_char = 8'h41;
            #1 chk($sformatf("v%0d_busy_check", n), 64'(busy), 64'd0);
            @(negedge clk);
            #1 chk($sformatf("v%0d_key_err", n), {key_err, busy, in_ready}, 64'b100);
            in_valid = 1'b0;
            return;
        end
        for (int cyc = 0; cyc < 80 && !done_seen; cyc++) begin
            out_ready = (cyc >= v.hold);
            in_valid  = (idx < v.len);
            in_char   = (idx < v.len) ? v.ch[31-8*idx -: 8] : 8'h00;
            #1;
            if (cyc == 1) chk($sformatf("v%0d_busy_run", n), 64'(busy), 64'd1);
            if (in_ready) begin
                idx++;
                if (cyc < v.hold) hs_hold++;
            end
            if (out_valid && out_ready) begin
                chk($sformatf("v%0d_out%0d", n, nout), {out_char, out_err, out_last},
                    {v.eo[31-8*nout -: 8], v.ee[nout], (nout == v.len-1)});
                last_cyc = cyc;
                nout++;
            end
            if (v.hold > 0 && cyc == v.hold - 1) begin
                chk($sformatf("v%0d_hold_accepted", n), 64'(hs_hold), 64'd2);
                chk($sformatf("v%0d_hold_in_ready", n), 64'(in_ready), 64'd0);
            end
            if (done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
            end
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk($sformatf("v%0d_done_seen", n), 64'(done_seen), 64'd1);
        chk($sformatf("v%0d_nout", n), 64'(nout), 64'(v.len));
        chk($sformatf("v%0d_done_after_last", n), 64'(done_cyc), 64'(last_cyc + 1));
        #1 chk($sformatf("v%0d_err_count", n), {err_count, busy}, {8'(v.ecnt), 1'b0});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{mode:0, d1:0, k1:3, d3:0, k3:5, len:2, ch:32'h417A0000,
                    eo:32'h51700000, ee:4'b0000, ecnt:0, kbad:0, hold:0};
        vecs[1] = '{mode:1, d1:0, k1:3, d3:0, k3:5, len:2, ch:32'h51700000,
                    eo:32'h417A0000, ee:4'b0000, ecnt:0, kbad:0, hold:0};
`ifdef PASSTHRU_NONLETTER_EN
        vecs[2] = '{mode:0, d1:0, k1:3, d3:0, k3:5, len:3, ch:32'h41207A00,
                    eo:32'h51207000, ee:4'b0000, ecnt:0, kbad:0, hold:0};
`else
        vecs[2] = '{mode:0, d1:0, k1:3, d3:0, k3:5, len:3, ch:32'h41207A00,
                    eo:32'h51007000, ee:4'b0010, ecnt:1, kbad:0, hold:0};
`endif
        vecs[3] = '{mode:0, d1:1, k1:2, d3:0, k3:0, len:4, ch:32'h61626364,
                    eo:32'h6768696A, ee:4'b0000, ecnt:0, kbad:0, hold:0};
        vecs[4] = '{mode:1, d1:1, k1:2, d3:1, k3:26, len:1, ch:32'h5A000000,
                    eo:32'h54000000, ee:4'b0000, ecnt:0, kbad:0, hold:0};
        vecs[5] = '{mode:0, d1:0, k1:3, d3:0, k3:5, len:4, ch:32'h61626364,
                    eo:32'h71727374, ee:4'b0000, ecnt:0, kbad:0, hold:7};
        vecs[6] = '{mode:0, d1:0, k1:27, d3:0, k3:5, len:2, ch:32'h41420000,
                    eo:32'h0, ee:4'b0000, ecnt:0, kbad:1, hold:0};

        rst_n = 1'b0; cfg_we = 1'b0; cfg_mode = 1'b0; cfg_d1 = 1'b0; cfg_k1 = 5'd0;
        cfg_d3 = 1'b0; cfg_k3 = 5'd0; start = 1'b0; msg_len = '0;
        in_valid = 1'b0; in_char = 8'h00; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_status", {busy, done, key_err, err_count, in_ready}, 64'd0);
        chk("reset_out", {out_valid, out_char, out_err, out_last}, 64'd0);
        chk("reset_core", {core_valid, core_ptxt, core_op, core_d1, core_k1, core_d3, core_k3},
            64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Equal keys rejected, then a config write clears key_err.
        do_cfg(1'b0, 1'b0, 5'd7, 1'b0, 5'd7);
        start = 1'b1; msg_len = 8'd2; in_valid = 1'b1; in_char = 8'h41;
        @(negedge clk);
        start = 1'b0;
        #1 chk("keq_busy_check", {busy, in_ready}, 64'd0);
        @(negedge clk);
        #1 chk("keq_key_err", {key_err, busy, in_ready}, 64'b100);
        @(negedge clk);
        #1 chk("keq_stays_idle", {key_err, busy, in_ready}, 64'b100);
        in_valid = 1'b0;
        do_cfg(1'b0, 1'b0, 5'd7, 1'b0, 5'd9);
        #1 chk("keq_cleared", 64'(key_err), 64'd0);

        // Reset during RUN with one character in flight.
        do_cfg(1'b0, 1'b0, 5'd3, 1'b0, 5'd5);
        start = 1'b1; msg_len = 8'd3; in_valid = 1'b1; in_char = 8'h41;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1 chk("rmid_first_accept", 64'(in_ready), 64'd1);
        @(negedge clk);
        #1 chk("rmid_inflight", {core_valid, core_ptxt, busy}, {1'b1, 8'h41, 1'b1});
        rst_n = 1'b0;
        #1;
        chk("rmid_status", {busy, done, key_err, err_count, in_ready}, 64'd0);
        chk("rmid_out", {out_valid, out_char, out_err, out_last}, 64'd0);
        chk("rmid_core", {core_valid, core_ptxt, core_op, core_d1, core_k1, core_d3, core_k3},
            64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk($sformatf("rmid_no_done%0d", i), {done, busy, out_valid}, 64'd0);
        end
        do_cfg(1'b0, 1'b0, 5'd3, 1'b0, 5'd5);
        start = 1'b1; msg_len = 8'd0;
        @(negedge clk);
        start = 1'b0;
        #1 chk("len0_cyc1", 64'(done), 64'd0);
        @(negedge clk);
        #1 chk("len0_cyc2_done", {done, busy, in_ready}, 64'b110);
        @(negedge clk);
        #1 chk("len0_cyc3", {done, busy}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
